// File: rtl/key_event_sequencer.sv
// key_event_sequencer: turns the held keyboard letter code into one press
// event per keystroke (stability filter + make/break FSM) and queues the
// events in a small FIFO drained by a valid/ready consumer.
`timescale 1ns/1ps
module key_event_sequencer #(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               letter,
    input  logic                     ev_ready,
    input  logic                     clr_ovf,
    output logic                     ev_valid,
    output logic [3:0]               ev_code,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     held,
    output logic [3:0]               held_code,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    // Internal codes are 6 bits wide so the invalid marker 32 is representable.
    localparam logic [5:0] CODE_BRK = 6'd17;
    localparam logic [5:0] CODE_INV = 6'd32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_BRK  = 2'd2;

    // Map the raw 5-bit code onto key (0-15), break prefix (17) or invalid (32).
    function automatic logic [5:0] norm_code(input logic [4:0] v);
        if (!v[4])
            return {1'b0, v};
        else if (v == 5'd17)
            return CODE_BRK;
        else
            return CODE_INV;
    endfunction

    logic [5:0]    raw;
    logic [5:0]    last_raw;
    logic [CW-1:0] cnt;
    logic [5:0]    filt;
    logic          chg;

    logic [1:0]    state;
    logic          filt_is_key;
    logic          push;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          ovf_set;

    assign raw = norm_code(letter);

    // Stability filter: accept a value once it has been seen STABLE_CYCLES times in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_raw <= CODE_INV;
            cnt      <= '0;
            filt     <= CODE_INV;
            chg      <= 1'b0;
        end else begin
            chg <= 1'b0;
            if (raw != last_raw) begin
                last_raw <= raw;
                cnt      <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    filt <= last_raw;
                    // Re-accepting the same value (glitch in between) is not a change.
                    chg  <= (last_raw != filt);
                end
            end
        end
    end

    assign filt_is_key = (filt[5:4] == 2'b00);

    // Press event: a new key code arrives while idle or while another key is held.
    always_comb begin
        push = 1'b0;
        if (chg && filt_is_key && (state == ST_IDLE || state == ST_HELD))
            push = 1'b1;
    end

    // Make/break FSM; it only moves on a filtered change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            held_code <= 4'd0;
        end else if (chg) begin
            case (state)
                ST_IDLE: begin
                    if (filt_is_key) begin
                        state     <= ST_HELD;
                        held_code <= filt[3:0];
                    end
                end
                ST_HELD: begin
                    if (filt_is_key)
                        held_code <= filt[3:0];
                    else if (filt == CODE_BRK)
                        state <= ST_BRK;
                    else
                        state <= ST_IDLE;
                end
                ST_BRK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign held = (state != ST_IDLE);

    assign full     = (count == FULL_CNT);
    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_en    = push && (!full || pop);
    assign ovf_set  = push && full && !pop;

    // FIFO storage; contents carry no reset, only the pointers and count do.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= filt[3:0];
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (ovf_set)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    assign ev_count = count;
    assign ev_code  = ev_valid ? mem[rd_ptr] : 4'd0;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Scoreboard bench for key_event_sequencer: expected press codes are queued
// as stimulus is issued; a monitor pops and compares on every accepted event.
`timescale 1ns/1ps
module tb_key_event_sequencer;

    localparam logic [4:0] BRK = 5'd17;
    localparam logic [4:0] INV = 5'd31;   // not a key nor 17, so treated as invalid

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] letter;
    logic       ev_ready;
    logic       clr_ovf;
    logic       ev_valid;
    logic [3:0] ev_code;
    logic [2:0] ev_count;
    logic       held;
    logic [3:0] held_code;
    logic       overflow;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];

    key_event_sequencer #(.STABLE_CYCLES(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .letter    (letter),
        .ev_ready  (ev_ready),
        .clr_ovf   (clr_ovf),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_count  (ev_count),
        .held      (held),
        .held_code (held_code),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every handshake the DUT completes must match the queue head.
    task automatic monitor();
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got code %0d, expected no event", ev_code);
                end else begin
                    check("event_code", ev_code, exp_q.pop_front());
                end
            end
        end
    endtask

    // Called at a negedge; holds v for n rising edges and returns at a negedge.
    task automatic hold(input logic [4:0] v, input int n);
        letter = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic keystroke(input logic [4:0] code);
        hold(code, 8);
        hold(BRK, 8);
        hold(code, 8);
        hold(INV, 8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ev_valid"},  ev_valid,  0);
        check({tag, "_ev_code"},   ev_code,   0);
        check({tag, "_ev_count"},  ev_count,  0);
        check({tag, "_held"},      held,      0);
        check({tag, "_held_code"}, held_code, 0);
        check({tag, "_overflow"},  overflow,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        letter   = INV;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        #1;
        check_reset_outputs("por");
        fork
            monitor();
        join_none
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold(INV, 4);

        // Basic press: visible 4 edges after the first sample, not before
        exp_q.push_back(4'd0);
        letter = 5'd0;
        repeat (4) @(negedge clk);
        check("press_not_before_e4", ev_valid, 0);
        @(negedge clk);
        check("press_ev_valid",  ev_valid,  1);
        check("press_ev_code",   ev_code,   0);
        check("press_held",      held,      1);
        check("press_held_code", held_code, 0);
        check("press_ev_count",  ev_count,  1);
        repeat (5) @(negedge clk);
        check("press_single_entry", ev_count, 1);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        check("press_drained", ev_count, 0);
        hold(BRK, 8);
        check("press_brk_held", held, 1);
        hold(INV, 8);
        check("press_released", held, 0);

        // Full keystroke with typematic repeat, consumer always ready
        ev_ready = 1'b1;
        exp_q.push_back(4'd5);
        hold(5'd5, 20);
        check("ks_held",      held,      1);
        check("ks_held_code", held_code, 5);
        hold(BRK, 8);
        check("ks_brk_held", held, 1);
        hold(5'd5, 8);
        check("ks_release_idle", held, 0);
        hold(INV, 8);
        check("ks_idle",        held,         0);
        check("ks_count",       ev_count,     0);
        check("ks_one_event",   exp_q.size(), 0);

        // Glitch rejection: 2 samples of 3 inside steady invalid
        hold(5'd3, 2);
        hold(INV, 10);
        check("glitch_ev_valid", ev_valid, 0);
        check("glitch_held",     held,     0);
        check("glitch_filt",     dut.filt, 32);

        // Rollover: 2 then 9 without break; release of 2 drops to idle, so 9 re-presses
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd9);
        hold(5'd2, 8);
        hold(5'd9, 8);
        check("roll_held_code", held_code, 9);
        check("roll_held",      held,      1);
        hold(BRK, 8);
        hold(5'd2, 8);
        check("roll_release_idle", held, 0);
        hold(BRK, 8);
        hold(5'd9, 8);
        check("roll_repress_held", held,      1);
        check("roll_repress_code", held_code, 9);
        hold(BRK, 8);
        hold(INV, 8);
        check("roll_final_idle", held,         0);
        check("roll_all_events", exp_q.size(), 0);

        // Overflow: five keystrokes into a 4-deep FIFO with no consumer
        ev_ready = 1'b0;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd4);
        keystroke(5'd1);
        keystroke(5'd2);
        keystroke(5'd3);
        keystroke(5'd4);
        check("ovf_not_yet", overflow, 0);
        keystroke(5'd6);
        check("ovf_count", ev_count, 4);
        check("ovf_flag",  overflow, 1);
        check("ovf_head",  ev_code,  1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared",     overflow, 0);
        check("ovf_count_kept",  ev_count, 4);

        // Push and pop on the same edge while full
        exp_q.push_back(4'd8);
        letter = 5'd8;
        repeat (4) @(negedge clk);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        check("pp_count",    ev_count, 4);
        check("pp_overflow", overflow, 0);
        check("pp_new_head", ev_code,  2);
        ev_ready = 1'b1;
        repeat (4) @(negedge clk);
        ev_ready = 1'b0;
        check("pp_drained",    ev_count,     0);
        check("pp_tail_order", exp_q.size(), 0);
        hold(BRK, 8);
        hold(INV, 8);

        // Asynchronous reset mid-stream
        hold(5'd10, 8);
        check("rst_pre_valid", ev_valid, 1);
        check("rst_pre_held",  held,     1);
        #2;
        rst    = 1'b1;
        letter = INV;
        exp_q.delete();
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        hold(INV, 6);
        check("post_rst_valid", ev_valid, 0);
        check("post_rst_held",  held,     0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
